// File: rtl/bus_pkg.sv
// Shared types and constants for the serial bus master port and its helpers.
package bus_pkg;

   localparam int ID_WIDTH        = 3;
   localparam int DEFAULT_TIMEOUT = 1023;

   localparam logic RD = 1'b0;
   localparam logic WR = 1'b1;

   typedef enum logic [3:0] {
      IDLE,
      REQ,
      SEND_ID,
      SEND_ADDR,
      SEND_DATA,
      WAIT_WR,
      WAIT_RD,
      RECV,
      DONE
   } bus_state_e;

   typedef struct packed {
      bus_state_e state;
      logic       serial_oe;
   } bus_dbg_t;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/bus_shift_reg.sv
// Parallel-load shift register, MSB first: PISO through ser_out, SIPO through par_next.
module bus_shift_reg #(
   parameter int WIDTH = 15,
   parameter int PAR_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             shift,
   input  logic             ser_in,
   output logic             ser_out,
   output logic [PAR_W-1:0] par_next
);

   logic [WIDTH-1:0] q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= '0;
      end else if (load) begin
         q <= load_val;
      end else if (shift) begin
         q <= {q[WIDTH-2:0], ser_in};
      end
   end

   assign ser_out = q[WIDTH-1];
   // Word as it will look after the current bit is shifted in.
   assign par_next = {q[PAR_W-2:0], ser_in};

endmodule

// File: rtl/bus_master_port.sv
// Master side of the serial memory bus: one parallel request in, one framed bus
// transaction out, one response back. Request handshake: transfer on req_valid & req_ready.
module bus_master_port #(
   parameter int ADDRESS_WIDTH = 15,
   parameter int DATA_WIDTH    = 8,
   parameter int ID_WIDTH      = bus_pkg::ID_WIDTH,
   parameter int TIMEOUT       = bus_pkg::DEFAULT_TIMEOUT
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic                     req_rd_wrt,
   input  logic [ID_WIDTH-1:0]      req_slave_id,
   input  logic [ADDRESS_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0]    req_wdata,
   output logic                     rsp_valid,
   output logic [DATA_WIDTH-1:0]    rsp_rdata,
   output logic                     rsp_err,
   output logic                     arbiter_req,
   input  logic                     arbiter_grant,
   output logic                     bus_util,
   output logic                     rd_wrt,
   input  logic                     slave_busy,
   inout  wire                      data_bus_serial,
   output bus_pkg::bus_dbg_t        dbg
);
   import bus_pkg::*;

   localparam int SR_W  = max3(ID_WIDTH, ADDRESS_WIDTH, DATA_WIDTH);
   localparam int BIT_W = $clog2(SR_W + 1);
   localparam int TO_W  = ($clog2(TIMEOUT + 1) > 10) ? $clog2(TIMEOUT + 1) : 10;

   bus_state_e                state_q, state_d;
   logic [BIT_W-1:0]          bit_cnt_q;
   logic [TO_W-1:0]           to_cnt_q;
   logic                      busy_seen_q;
   logic                      wr_q;
   logic [ID_WIDTH-1:0]       id_q;
   logic [ADDRESS_WIDTH-1:0]  addr_q;
   logic [DATA_WIDTH-1:0]     wdata_q;
   logic                      sr_load, sr_shift, sr_out;
   logic [SR_W-1:0]           sr_load_val;
   logic [DATA_WIDTH-1:0]     rx_word;
   logic                      rdata_load, err_d, timeout_hit, serial_oe;

   assign timeout_hit = (to_cnt_q == TO_W'(TIMEOUT - 1));

   always_comb begin
      state_d     = state_q;
      sr_load     = 1'b0;
      sr_load_val = '0;
      sr_shift    = 1'b0;
      rdata_load  = 1'b0;
      err_d       = 1'b0;
      case (state_q)
         IDLE: if (req_valid) state_d = REQ;
         REQ: begin
            if (arbiter_grant) begin
               state_d     = SEND_ID;
               sr_load     = 1'b1;
               sr_load_val = SR_W'(id_q) << (SR_W - ID_WIDTH);
            end
         end
         SEND_ID: begin
            if (bit_cnt_q == BIT_W'(ID_WIDTH - 1)) begin
               state_d     = SEND_ADDR;
               sr_load     = 1'b1;
               sr_load_val = SR_W'(addr_q) << (SR_W - ADDRESS_WIDTH);
            end else begin
               sr_shift = 1'b1;
            end
         end
         SEND_ADDR: begin
            if (bit_cnt_q == BIT_W'(ADDRESS_WIDTH - 1)) begin
               state_d     = (wr_q == WR) ? SEND_DATA : WAIT_RD;
               sr_load     = (wr_q == WR);
               sr_load_val = SR_W'(wdata_q) << (SR_W - DATA_WIDTH);
            end else begin
               sr_shift = 1'b1;
            end
         end
         SEND_DATA: begin
            if (bit_cnt_q == BIT_W'(DATA_WIDTH - 1)) state_d = WAIT_WR;
            else sr_shift = 1'b1;
         end
         WAIT_WR: begin
            if (busy_seen_q && !slave_busy) begin
               state_d = DONE;
            end else if (timeout_hit) begin
               state_d = DONE;
               err_d   = 1'b1;
            end
         end
         WAIT_RD: begin
            // Start bit from the slave; an undriven (z) line never qualifies.
            if (data_bus_serial == 1'b1) begin
               state_d = RECV;
            end else if (timeout_hit) begin
               state_d = DONE;
               err_d   = 1'b1;
            end
         end
         RECV: begin
            sr_shift = 1'b1;
            if (bit_cnt_q == BIT_W'(DATA_WIDTH - 1)) begin
               state_d    = DONE;
               rdata_load = 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         bit_cnt_q   <= '0;
         to_cnt_q    <= '0;
         busy_seen_q <= 1'b0;
         wr_q        <= 1'b0;
         id_q        <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rsp_rdata   <= '0;
         rsp_err     <= 1'b0;
      end else begin
         state_q <= state_d;
         // Counters and the busy latch restart on every phase change.
         if (state_d != state_q) begin
            bit_cnt_q   <= '0;
            to_cnt_q    <= '0;
            busy_seen_q <= slave_busy;
         end else begin
            if (state_q inside {SEND_ID, SEND_ADDR, SEND_DATA, RECV}) bit_cnt_q <= bit_cnt_q + 1'b1;
            if (state_q inside {WAIT_WR, WAIT_RD}) to_cnt_q <= to_cnt_q + 1'b1;
            if (state_q == WAIT_WR && slave_busy) busy_seen_q <= 1'b1;
         end
         if (state_q == IDLE && req_valid) begin
            wr_q    <= req_rd_wrt;
            id_q    <= req_slave_id;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
         end
         if (rdata_load) rsp_rdata <= rx_word;
         if (state_d == DONE && state_q != DONE) rsp_err <= err_d;
      end
   end

   bus_shift_reg #(
      .WIDTH (SR_W),
      .PAR_W (DATA_WIDTH)
   ) u_shift (
      .clk      (clk),
      .rst      (rst),
      .load     (sr_load),
      .load_val (sr_load_val),
      .shift    (sr_shift),
      .ser_in   (data_bus_serial),
      .ser_out  (sr_out),
      .par_next (rx_word)
   );

   always_comb begin
      req_ready   = (state_q == IDLE);
      rsp_valid   = (state_q == DONE);
      arbiter_req = state_q inside {REQ, SEND_ID, SEND_ADDR, SEND_DATA, WAIT_WR, WAIT_RD, RECV};
      bus_util    = state_q inside {SEND_ID, SEND_ADDR, SEND_DATA, WAIT_WR, WAIT_RD, RECV};
      rd_wrt      = bus_util & wr_q;
      serial_oe   = state_q inside {SEND_ID, SEND_ADDR, SEND_DATA};
      dbg.state     = state_q;
      dbg.serial_oe = serial_oe;
   end

   assign data_bus_serial = serial_oe ? sr_out : 1'bz;

endmodule

// File: tb/tb_bus_master_port.sv
// Randomised bench for bus_master_port acting as core, arbiter and slave set (slave 7 absent).
module tb_bus_master_port;

   localparam int TIMEOUT    = 16;
   localparam int ABSENT_ID  = 7;
   localparam int WAIT_LIMIT = 40;

   typedef struct {
      bit        wr;
      bit [2:0]  id;
      bit [14:0] addr;
      bit [7:0]  wdata;
      int        gd;
      int        a;
      int        b;
      bit [7:0]  rdata;
   } txn_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_rd_wrt = 1'b0;
   logic [2:0]  req_slave_id = '0;
   logic [14:0] req_addr = '0;
   logic [7:0]  req_wdata = '0;
   logic        rsp_valid;
   logic [7:0]  rsp_rdata;
   logic        rsp_err;
   logic        arbiter_req;
   logic        arbiter_grant = 1'b0;
   logic        bus_util;
   logic        rd_wrt;
   logic        slave_busy = 1'b0;
   wire         data_bus_serial;
   bus_pkg::bus_dbg_t dbg;

   logic        tb_en = 1'b0;
   logic        tb_val = 1'b0;
   assign data_bus_serial = tb_en ? tb_val : 1'bz;

   int          checks = 0;
   int          errors = 0;
   logic [8:0]  exp_q[$];
   logic [7:0]  last_rdata = '0;

   bus_master_port #(.TIMEOUT(TIMEOUT)) dut (
      .clk             (clk),
      .rst             (rst),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_rd_wrt      (req_rd_wrt),
      .req_slave_id    (req_slave_id),
      .req_addr        (req_addr),
      .req_wdata       (req_wdata),
      .rsp_valid       (rsp_valid),
      .rsp_rdata       (rsp_rdata),
      .rsp_err         (rsp_err),
      .arbiter_req     (arbiter_req),
      .arbiter_grant   (arbiter_grant),
      .bus_util        (bus_util),
      .rd_wrt          (rd_wrt),
      .slave_busy      (slave_busy),
      .data_bus_serial (data_bus_serial),
      .dbg             (dbg)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic drive_req(input txn_t t);
      req_valid    = 1'b1;
      req_rd_wrt   = t.wr;
      req_slave_id = t.id;
      req_addr     = t.addr;
      req_wdata    = t.wdata;
   endtask

   // One full request/response; called and returning at a negedge with the DUT idle.
   task automatic run_txn(input txn_t t, input bit hold, input txn_t nxt);
      bit present;
      bit fbits[$];
      int exp_lat;
      int j;
      int idx;
      bit seen;
      logic [8:0] exp_rsp;

      present = (t.id != ABSENT_ID);
      for (int i = 2; i >= 0; i--) fbits.push_back(t.id[i]);
      for (int i = 14; i >= 0; i--) fbits.push_back(t.addr[i]);
      if (t.wr) for (int i = 7; i >= 0; i--) fbits.push_back(t.wdata[i]);

      if (!present) begin
         exp_q.push_back({1'b1, last_rdata});
         exp_lat = TIMEOUT;
      end else if (t.wr) begin
         exp_q.push_back({1'b0, last_rdata});
         exp_lat = t.a + t.b + 1;
      end else begin
         last_rdata = t.rdata;
         exp_q.push_back({1'b0, t.rdata});
         exp_lat = t.a + 1 + 8;
      end

      check("accept_ready", req_ready, 1);
      drive_req(t);
      @(negedge clk);
      if (hold) drive_req(nxt);
      else req_valid = 1'b0;

      for (int i = 0; i <= t.gd; i++) begin
         check("req_phase", {arbiter_req, bus_util, dbg.serial_oe, req_ready, rsp_valid}, 5'b10000);
         arbiter_grant = (i == t.gd);
         @(negedge clk);
      end

      foreach (fbits[k]) begin
         check("frame", {arbiter_req, bus_util, dbg.serial_oe, req_ready, rsp_valid, rd_wrt, data_bus_serial},
               {5'b11100, t.wr, fbits[k]});
         arbiter_grant = 1'($urandom_range(0, 1));
         @(negedge clk);
      end

      seen = 1'b0;
      j = 0;
      while (j < WAIT_LIMIT && !seen) begin
         if (rsp_valid === 1'b1) begin
            seen = 1'b1;
         end else begin
            check("wait_phase", {arbiter_req, bus_util, dbg.serial_oe, req_ready, rd_wrt}, {4'b1100, t.wr});
            if (present && t.wr) slave_busy = (j >= t.a && j < t.a + t.b);
            if (present && !t.wr) begin
               tb_en = (j >= t.a && j < t.a + 9);
               idx = 7 - (j - t.a - 1);
               tb_val = (j == t.a) ? 1'b1 : ((idx >= 0 && idx <= 7) ? t.rdata[idx] : 1'b0);
            end
            arbiter_grant = 1'($urandom_range(0, 1));
            @(negedge clk);
            j++;
         end
      end

      exp_rsp = exp_q.pop_front();
      check("rsp_seen", seen, 1);
      if (seen) begin
         check("latency", j, exp_lat);
         check("done_phase", {arbiter_req, bus_util, dbg.serial_oe, req_ready}, 4'b0000);
         check("rsp", {rsp_err, rsp_rdata}, exp_rsp);
      end

      slave_busy    = 1'b0;
      tb_en         = 1'b0;
      arbiter_grant = 1'b0;
      @(negedge clk);
      check("idle", {req_ready, rsp_valid, arbiter_req, bus_util, dbg.serial_oe}, 5'b10000);
   endtask

   initial begin
      txn_t t, t2;

      // Reset state
      @(negedge clk);
      @(negedge clk);
      check("reset_ctrl", {req_ready, rsp_valid, rsp_err, arbiter_req, bus_util, rd_wrt, dbg.serial_oe}, 7'b1000000);
      check("reset_rdata", rsp_rdata, 0);
      rst = 1'b0;
      @(negedge clk);

      // Directed write: id 3, addr 0ABC, data A5, grant after 2 cycles
      t = '{wr: 1'b1, id: 3'd3, addr: 15'h0ABC, wdata: 8'hA5, gd: 2, a: 1, b: 2, rdata: 8'h00};
      run_txn(t, 1'b0, t);

      // Directed read: id 0, addr 0001, slave returns 3C
      t = '{wr: 1'b0, id: 3'd0, addr: 15'h0001, wdata: 8'h00, gd: 0, a: 0, b: 1, rdata: 8'h3C};
      run_txn(t, 1'b0, t);

      // Read from absent slave: timeout, rdata held at 3C
      t = '{wr: 1'b0, id: 3'd7, addr: 15'h7FFF, wdata: 8'h00, gd: 1, a: 0, b: 1, rdata: 8'hFF};
      run_txn(t, 1'b0, t);

      // Grant withheld for 50 cycles
      t = '{wr: 1'b1, id: 3'd1, addr: 15'h4321, wdata: 8'h0F, gd: 50, a: 0, b: 1, rdata: 8'h00};
      run_txn(t, 1'b0, t);

      // req_valid held across two back-to-back requests
      t  = '{wr: 1'b0, id: 3'd2, addr: 15'h1555, wdata: 8'h00, gd: 1, a: 3, b: 1, rdata: 8'hC3};
      t2 = '{wr: 1'b1, id: 3'd5, addr: 15'h2AAA, wdata: 8'h96, gd: 0, a: 2, b: 3, rdata: 8'h00};
      run_txn(t, 1'b1, t2);
      run_txn(t2, 1'b0, t2);

      // Reset in the middle of the address phase
      t = '{wr: 1'b1, id: 3'd2, addr: 15'h1234, wdata: 8'h5A, gd: 0, a: 0, b: 1, rdata: 8'h00};
      drive_req(t);
      @(negedge clk);
      req_valid = 1'b0;
      arbiter_grant = 1'b1;
      @(negedge clk);
      arbiter_grant = 1'b0;
      repeat (5) @(negedge clk);
      check("pre_rst_frame", {bus_util, dbg.serial_oe}, 2'b11);
      rst = 1'b1;
      #1;
      check("rst_mid_frame", {arbiter_req, bus_util, dbg.serial_oe, rsp_valid, rd_wrt, rsp_err}, 6'b000000);
      check("rst_mid_rdata", rsp_rdata, 0);
      @(negedge clk);
      rst = 1'b0;
      last_rdata = '0;
      for (int i = 0; i < 30; i++) begin
         check("post_rst", {req_ready, rsp_valid, arbiter_req, bus_util, dbg.serial_oe}, 5'b10000);
         @(negedge clk);
      end

      // Randomised traffic, including the absent slave
      for (int n = 0; n < 40; n++) begin
         t.wr    = 1'($urandom_range(0, 1));
         t.id    = 3'($urandom_range(0, 7));
         t.addr  = 15'($urandom);
         t.wdata = 8'($urandom);
         t.gd    = $urandom_range(0, 6);
         t.a     = $urandom_range(0, 5);
         t.b     = $urandom_range(1, 4);
         t.rdata = 8'($urandom);
         run_txn(t, 1'b0, t);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
